// File: rtl/fpu_pkg.sv
// Shared FP32 add/sub constants, operand type and the round-robin grant helper.
// Pure declarations; no latency, no flow control.
package fpu_pkg;

    localparam int FP_W            = 32;
    localparam int FP_SIGN         = 31;
    localparam int FADDSUB_LATENCY = 3;

    typedef logic [FP_W-1:0] fp32_t;

    // One-hot grant to the first set bit of elig strictly after ptr, wrapping at n (n <= 8).
    function automatic logic [7:0] rr_arb(input logic [7:0] elig, input int unsigned n,
                                          input int unsigned ptr);
        logic [7:0]  gnt;
        logic        found;
        int unsigned idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= 8; k++) begin
            if (k <= n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && elig[idx[2:0]]) begin
                    gnt[idx[2:0]] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/fpu_tag_pipe.sv
// Valid+id delay line tracking ops in the shared datapath; DEPTH cycles, advances every cycle.
// No backpressure: the datapath never stalls, so neither does the tag line.
module fpu_tag_pipe
    import fpu_pkg::*;
#(
    parameter int DEPTH = FADDSUB_LATENCY,
    parameter int ID_W  = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_vld_i,
    input  logic [ID_W-1:0] in_id_i,
    output logic            out_vld_o,
    output logic [ID_W-1:0] out_id_o,
    output logic            busy_o
);

    logic [DEPTH-1:0] vld_q;
    logic [ID_W-1:0]  id_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld_i;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // Ids are only meaningful alongside a set vld bit, so they need no reset.
    always_ff @(posedge clk_i) begin
        id_q[0] <= in_id_i;
        for (int k = 1; k < DEPTH; k++) begin
            id_q[k] <= id_q[k-1];
        end
    end

    assign out_vld_o = vld_q[DEPTH-1];
    assign out_id_o  = id_q[DEPTH-1];
    assign busy_o    = |vld_q;

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin sharing of one FP32 add/sub pipe among N_REQ requesters; grant is same-cycle,
// result returns LATENCY cycles after issue; per-requester in-flight cap, results never stall.
module fpu_addsub_arbiter
    import fpu_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int LATENCY      = FADDSUB_LATENCY,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    input  logic [FP_W*N_REQ-1:0] req_op1_i,
    input  logic [FP_W*N_REQ-1:0] req_op2_i,
    input  logic [N_REQ-1:0]      req_sub_i,
    output logic [N_REQ-1:0]      req_ready_o,
    output logic [N_REQ-1:0]      rsp_valid_o,
    output logic [FP_W-1:0]       rsp_result_o,
    output logic                  rsp_uflow_o,
    output logic [FP_W-1:0]       pipe_op1_o,
    output logic [FP_W-1:0]       pipe_op2_o,
    input  logic [FP_W-1:0]       pipe_result_i,
    input  logic                  pipe_ok_i,
    output logic                  busy_o
);

    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q [N_REQ];
    logic [CNT_W-1:0] cnt_d [N_REQ];
    fp32_t            last_q, last_d;

    logic [N_REQ-1:0] elig;
    logic [7:0]       gnt_full;
    logic [N_REQ-1:0] gnt;
    logic             hs;
    logic [ID_W-1:0]  win_id;
    fp32_t            op1_mux, op2_mux;

    logic             tag_vld;
    logic [ID_W-1:0]  tag_id;
    logic             retire;
    logic [N_REQ-1:0] ret_oh;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid_i[i] && (cnt_q[i] < CNT_W'(MAX_INFLIGHT)) && !rst_i;
        end
    end

    assign gnt_full = rr_arb(8'(elig), N_REQ, 32'(rr_ptr_q));
    assign gnt      = gnt_full[N_REQ-1:0];
    assign hs       = |gnt;

    generate
        if (N_REQ < 8) begin : g_pad
            logic unused_gnt;
            assign unused_gnt = ^gnt_full[7:N_REQ];
        end
    endgenerate

    // Addition is issued as op1 - (-op2) by flipping the op2 sign when req_sub is low.
    always_comb begin
        win_id  = '0;
        op1_mux = '0;
        op2_mux = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                win_id           = ID_W'(i);
                op1_mux          = req_op1_i[FP_W*i +: FP_W];
                op2_mux          = req_op2_i[FP_W*i +: FP_W];
                op2_mux[FP_SIGN] = op2_mux[FP_SIGN] ^ ~req_sub_i[i];
            end
        end
    end

    assign req_ready_o = gnt;
    assign pipe_op1_o  = op1_mux;
    assign pipe_op2_o  = op2_mux;

    fpu_tag_pipe #(
        .DEPTH (LATENCY),
        .ID_W  (ID_W)
    ) u_tag_pipe (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_vld_i  (hs),
        .in_id_i   (win_id),
        .out_vld_o (tag_vld),
        .out_id_o  (tag_id),
        .busy_o    (busy_o)
    );

    // A retire in the reset cycle belongs to an op being dropped.
    assign retire = tag_vld && !rst_i;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            ret_oh[i] = retire && (tag_id == ID_W'(i));
        end
    end

    assign rsp_valid_o  = ret_oh;
    assign rsp_uflow_o  = retire && !pipe_ok_i;
    assign rsp_result_o = retire ? pipe_result_i : last_q;

    always_comb begin
        rr_ptr_d = hs ? win_id : rr_ptr_q;
        last_d   = retire ? pipe_result_i : last_q;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gnt[i] && !ret_oh[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!gnt[i] && ret_oh[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= ID_W'(N_REQ - 1);
            last_q   <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            last_q   <= last_d;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
